// File: rtl/mc_control_v2_if.sv
// mc_control_v2_if: bus bundle between the datapath/sequencer and the
// multicycle control unit.
//   master : drives OpCode, IMemRdy, Stall; observes all control outputs
//   slave  : the control unit; observes inputs, drives decode/strobes,
//            Halted, Retired and StateOut
interface mc_control_v2_if #(
    parameter int OP_W  = 5,
    parameter int CNT_W = 16
);
    logic [OP_W-1:0]  OpCode;
    logic             IMemRdy;
    logic             Stall;
    logic [3:0]       ULA_OP;
    logic             ULA_B;
    logic             EscIR;
    logic             EscCP;
    logic             EscCondCP;
    logic             EscReg;
    logic             WEnPC;
    logic             IsMulWB;
    logic             HILO;
    logic             HILO_WB;
    logic             MulStart;
    logic             Halted;
    logic [CNT_W-1:0] Retired;
    logic [2:0]       StateOut;

    modport master (
        output OpCode, IMemRdy, Stall,
        input  ULA_OP, ULA_B, EscIR, EscCP, EscCondCP, EscReg, WEnPC,
               IsMulWB, HILO, HILO_WB, MulStart, Halted, Retired, StateOut
    );

    modport slave (
        input  OpCode, IMemRdy, Stall,
        output ULA_OP, ULA_B, EscIR, EscCP, EscCondCP, EscReg, WEnPC,
               IsMulWB, HILO, HILO_WB, MulStart, Halted, Retired, StateOut
    );
endinterface

// File: rtl/mc_control_v2.sv
// mc_control_v2: multicycle control unit for the 16-bit datapath.
// Sequences IF -> ID -> RF -> EX -> (MW x MUL_LAT) -> WB, with HLT as an
// absorbing state, and decodes OpCode into ALU/mux/write-enable controls.
// Ports:
//   CLK      clock
//   RST      synchronous active-high reset
//   bus      mc_control_v2_if slave modport
//            in : OpCode, IMemRdy, Stall
//            out: ULA_OP, ULA_B, EscIR, EscCP, EscCondCP, EscReg, WEnPC,
//                 IsMulWB, HILO, HILO_WB, MulStart, Halted, Retired,
//                 StateOut
// OP_W and CNT_W must match the interface instance.
module mc_control_v2 #(
    parameter int OP_W    = 5,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic           CLK,
    input  logic           RST,
    mc_control_v2_if.slave bus
);
    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_RF  = 3'd2;
    localparam logic [2:0] S_EX  = 3'd3;
    localparam logic [2:0] S_MW  = 3'd4;
    localparam logic [2:0] S_WB  = 3'd5;
    localparam logic [2:0] S_HLT = 3'd6;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLT = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_XOR = 4'd5;
    localparam logic [3:0] ALU_BEZ = 4'd6;

    // Counter is loaded on MW entry so that MW lasts exactly MUL_LAT cycles.
    localparam logic [3:0] MW_LOAD = 4'(MUL_LAT - 1);

    logic [2:0]       state_q, state_d;
    logic [3:0]       mw_cnt_q, mw_cnt_d;
    logic [CNT_W-1:0] ret_q, ret_d;

    logic [OP_W-1:0]  op;
    logic             base;
    logic [3:0]       low;
    logic             is_mul, is_halt, no_wr, run;

    assign op      = bus.OpCode;
    assign base    = ~op[4];
    assign low     = op[3:0];
    assign is_mul  = base && (low == 4'd13);
    assign is_halt = !base && (low == 4'd1);
    // No register write for J, BEZ, MUL, and the whole extension set.
    assign no_wr   = !base || (low == 4'd11) || (low == 4'd12) || (low == 4'd13);
    assign run     = ~bus.Stall;

    always_comb begin
        state_d  = state_q;
        mw_cnt_d = mw_cnt_q;
        ret_d    = ret_q;
        case (state_q)
            S_IF:  if (run && bus.IMemRdy) state_d = S_ID;
            S_ID:  if (run) state_d = S_RF;
            S_RF:  if (run) state_d = S_EX;
            S_EX:  if (run) begin
                       if (is_mul) begin
                           state_d  = S_MW;
                           mw_cnt_d = MW_LOAD;
                       end else begin
                           state_d  = S_WB;
                       end
                   end
            S_MW:  if (run) begin
                       if (mw_cnt_q == 4'd0) state_d  = S_WB;
                       else                  mw_cnt_d = mw_cnt_q - 4'd1;
                   end
            S_WB:  if (run) begin
                       ret_d   = ret_q + 1'b1;
                       state_d = is_halt ? S_HLT : S_IF;
                   end
            S_HLT: state_d = S_HLT;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IF;
            mw_cnt_q <= 4'd0;
            ret_q    <= '0;
        end else begin
            state_q  <= state_d;
            mw_cnt_q <= mw_cnt_d;
            ret_q    <= ret_d;
        end
    end

    // Moore strobes; the write-type strobes are suppressed while stalled.
    assign bus.EscIR    = run && (state_q == S_ID);
    assign bus.MulStart = run && (state_q == S_EX) && is_mul;
    assign bus.WEnPC    = run && (state_q == S_WB) && !is_halt;
    assign bus.EscReg   = run && (state_q == S_WB) && !no_wr;
    assign bus.Halted   = (state_q == S_HLT);
    assign bus.Retired  = ret_q;
    assign bus.StateOut = state_q;

    // Opcode decode is purely combinational and state-independent.
    always_comb begin
        bus.ULA_OP    = ALU_ADD;
        bus.ULA_B     = 1'b0;
        bus.EscCP     = 1'b0;
        bus.EscCondCP = 1'b0;
        bus.IsMulWB   = 1'b0;
        bus.HILO      = 1'b0;
        bus.HILO_WB   = 1'b0;
        if (base) begin
            case (low)
                4'd0:  bus.ULA_OP = ALU_ADD;
                4'd1:  bus.ULA_OP = ALU_SUB;
                4'd2:  begin bus.ULA_OP = ALU_SLT; bus.ULA_B = 1'b1; end
                4'd3:  bus.ULA_OP = ALU_AND;
                4'd4:  bus.ULA_OP = ALU_OR;
                4'd5:  bus.ULA_OP = ALU_XOR;
                4'd6:  begin bus.ULA_OP = ALU_AND; bus.ULA_B = 1'b1; end
                4'd7:  begin bus.ULA_OP = ALU_OR;  bus.ULA_B = 1'b1; end
                4'd8:  begin bus.ULA_OP = ALU_XOR; bus.ULA_B = 1'b1; end
                4'd9:  begin bus.ULA_OP = ALU_ADD; bus.ULA_B = 1'b1; end
                4'd10: begin bus.ULA_OP = ALU_SUB; bus.ULA_B = 1'b1; end
                4'd11: bus.EscCP = 1'b1;
                4'd12: begin bus.ULA_OP = ALU_BEZ; bus.EscCondCP = 1'b1; end
                4'd13: bus.IsMulWB = 1'b1;
                4'd14: begin bus.HILO = 1'b1; bus.HILO_WB = 1'b1; end
                default: bus.HILO_WB = 1'b1;
            endcase
        end
    end
endmodule
